// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller feeding CP0 HWInt: synchronises the request lines,
// latches them level/edge pending, masks them, and pulses ext_ack on ACK register writes.
module int_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
    parameter int unsigned NSRC      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_src,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       byteen,
    output logic [31:0]      rdata,
    output logic             hit,
    output logic [NSRC-1:0]  hwint,
    output logic             ext_ack
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned PAD_W = 32 - 1 - IDX_W;

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_MODE = 2'd2;
    localparam logic [1:0] OFF_ID   = 2'd3;

    logic [NSRC-1:0]  r_s1;
    logic [NSRC-1:0]  r_s2;
    logic [NSRC-1:0]  r_s3;
    logic [NSRC-1:0]  r_pend;
    logic [NSRC-1:0]  r_mask;
    logic [NSRC-1:0]  r_mode;

    logic [1:0]       w_off;
    logic             w_wr_any;
    logic             w_wr_b0;
    logic             w_ack_wr;
    logic [NSRC-1:0]  w_clr;
    logic [NSRC-1:0]  w_rise;
    logic [NSRC-1:0]  w_pend_nxt;
    logic [NSRC-1:0]  w_pm;
    logic             w_id_valid;
    logic [IDX_W-1:0] w_id_idx;
    logic             w_unused;

    assign hit      = (addr & 32'hFFFF_FFF0) == BASE_ADDR;
    assign w_off    = addr[3:2];
    assign w_wr_any = hit && (byteen != 4'b0000);
    assign w_wr_b0  = hit && byteen[0];
    assign w_ack_wr = w_wr_any && (w_off == OFF_PEND);
    assign w_clr    = (w_wr_b0 && (w_off == OFF_PEND)) ? wdata[NSRC-1:0] : '0;
    assign w_unused = &{1'b0, wdata[31:NSRC], addr[1:0]};

    // Two-flop synchroniser plus a history flop for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= irq_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Edge sources hold until W1C (a same-cycle set wins); level sources follow the line
    assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & r_s2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_mode  <= '0;
            hwint   <= '0;
            ext_ack <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            hwint   <= r_pend & r_mask;
            ext_ack <= w_ack_wr;
            if (w_wr_b0 && (w_off == OFF_MASK)) begin
                r_mask <= wdata[NSRC-1:0];
            end
            if (w_wr_b0 && (w_off == OFF_MODE)) begin
                r_mode <= wdata[NSRC-1:0];
            end
        end
    end

    assign w_pm = r_pend & r_mask;

    // Lowest-numbered active source wins, so scan from the top and let lower bits overwrite
    always_comb begin
        w_id_valid = 1'b0;
        w_id_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_pm[i]) begin
                w_id_valid = 1'b1;
                w_id_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (w_off)
                OFF_PEND: rdata = 32'(r_pend);
                OFF_MASK: rdata = 32'(r_mask);
                OFF_MODE: rdata = 32'(r_mode);
                OFF_ID:   rdata = {w_id_valid, {PAD_W{1'b0}}, w_id_idx};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller between the peripheral/external interrupt sources and the CPU's CP0 `HWInt` inputs. It synchronises six request lines, latches them as level- or edge-triggered pending bits, masks them, and presents the result to CP0. It is decoded on the CPU data bus at `BASE_ADDR` and returns a registered acknowledge pulse to the external requester when software writes the ACK register.

## Interface
- `BASE_ADDR`, default `32'h0000_7F20`: 16-byte aligned window base.
- `NSRC`, default `6`: number of sources. Fixed at 6 in this revision.

- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: one clock domain; reset is asynchronous and active-low (0 = reset).
- `irq_src`, input, 6: raw requests. bit0 = timer0, bit1 = timer1, bit2 = external interrupt, bits 5:3 = spare. They are asynchronous.
- `addr`, input, 32: CPU data address.
- `wdata`, input, 32: CPU write data.
- `byteen`, input, 4: byte write enables. Any nonzero value is a write.
- `rdata`, output, 32: read data. Combinational; 0 when the address misses the window.
- `hit`, output, 1: combinational, `(addr & 32'hFFFF_FFF0) == BASE_ADDR`.
- `hwint`, output, 6: registered `pend & mask` to CP0.
- `ext_ack`, output, 1: one-cycle acknowledge pulse to the external source.

## Operation
- **Synchroniser.** Each `irq_src` bit passes through two flops, `s1` then `s2`. A third flop `s3` holds the previous `s2`. The rising-edge event is `rise = s2 & ~s3`.
- **Registers.** Offset is `addr[3:2]`. Writes use `wdata[5:0]` and take effect only when `hit` and `byteen[0]` are both set. Upper bits read as 0.
  - `00` PEND/ACK:
    - Read returns `pend`.
    - Write-1-to-clear on `pend`.
    - Any write (`hit` and any `byteen`) schedules `ext_ack`, regardless of `byteen[0]`.
  - `01` MASK: read/write, reset 0.
  - `10` MODE: read/write, reset 0. Bit i = 1 makes source i rising-edge triggered; 0 makes it level triggered.
  - `11` ID: read-only.
    - `{valid, 26'b0, idx[4:0]}`.
    - idx is the lowest set bit of `pend & mask`; bit 0 has highest priority.
    - When no bit is set, valid = 0 and idx = 0.
- **Pending update per source i, each clock:**
  - Level mode: `pend[i] <= s2[i]`. A W1C has no lasting effect while the line stays high.
  - Edge mode: `pend[i] <= rise[i] | (pend[i] & ~clr[i])`, with `clr = wdata[5:0]` on a qualifying ACK write. If a set and a clear land in the same cycle, set wins.
  - Changing MODE takes effect from the next edge. Stored `pend` bits are not altered by the mode change itself.
- **hwint.** `hwint <= pend & mask`, registered one cycle after `pend`. A MASK write affects `hwint` on the second clock edge after the write cycle.
- **ext_ack.** Set for exactly one cycle on the clock edge after an ACK write. Back-to-back ACK writes give back-to-back pulses.
- **Reset.** When `reset` is 0, all flops clear asynchronously: `s1`, `s2`, `s3`, `pend`, `mask`, `mode`, `hwint` and `ext_ack` all go to 0. A reset mid-operation drops `hwint` immediately and loses all pending state. The first edge after release behaves as a fresh start: a source already high gives `rise` after synchronisation.

## Timing
- **Source to `hwint` latency** (unmasked, counted from the first edge that samples the source high):
  - edge E: `s1`
  - E+1: `s2`
  - E+2: `pend`
  - E+3: `hwint`
- Reads are combinational in the same cycle. The read value reflects register state before the current edge.
- The W1C of an edge source removes `pend` at the write edge and `hwint` one edge later.
- A level source going low takes 4 edges to clear `hwint`. This path has no W1C.
- Reset output values: `rdata` = 0 (no hit), `hit` follows `addr`, `hwint` = 0, `ext_ack` = 0.

## Test plan
- **Reset.**
  - Stimulus: assert `reset` = 0 mid-run with MASK = `3F`, `pend` = `04`, `hwint` = `04`.
  - Required: `hwint` = 0 and `ext_ack` = 0 immediately; reads of MASK, MODE and PEND return 0 after release.
- **Level path.**
  - Stimulus: MASK = `01`, MODE = 0; hold `irq_src[0]` high.
  - Required: `hwint` = `01` on the 4th edge after first sampling. A W1C of `01` does not clear it.
  - Stimulus: drop the source.
  - Required: `hwint` = 0 four edges later.
- **Edge plus ACK**, matching the external-interrupt handshake.
  - Stimulus: MASK = `04`, MODE = `04`; raise `irq_src[2]` and hold it.
  - Required: `hwint` = `04` and stays `04`.
  - Stimulus: write `0x7F20` with `wdata` = 4, `byteen` = `F`.
  - Required: `pend` = 0 at that edge, `hwint` = 0 next edge, `ext_ack` high for exactly 1 cycle.
  - Required: no re-trigger while the source stays high.
- **Set/clear collision.**
  - Stimulus: edge mode on bit 1, `pend[1]` = 1; W1C bit 1 in the same cycle that `rise[1]` is 1.
  - Required: `pend[1]` remains 1.
- **Priority/ID.**
  - Stimulus: `pend` = `2C`, MASK = `28`.
  - Required: ID reads `0x8000_0003`.
  - Stimulus: MASK = 0.
  - Required: ID reads `0x0000_0000`.
- **Decode.**
  - Stimulus: write to `0x7F30` and to `0x7F1C`.
  - Required: `hit` = 0, no register change, no `ext_ack`.
  - Stimulus: write to `0x7F20` with `byteen` = `2`.
  - Required: `ext_ack` pulses, `pend` unchanged.
